pcm_serial_rx: RTL and testbench
================================

// Module: pcm_serial_rx
// PURPOSE
//  Front end of the multichannel ADPCM encoder. Recovers 8-bit PCM code words from a TDM serial
//  line (frame sync plus bit strobe) and tags each word with its channel number. Words are buffered
//  in a small FIFO and handed to the IN_PCM input-conversion stage (its S input) over a valid/ready
//  handshake. Line framing, mis-alignment and overruns are detected and flagged here.
// PARAMETERS
//  NCH      32  channels (time slots) per frame, 8 bits per slot, MSB first
//  CH_W     5   channel-number width, clog2(NCH)
//  FDEPTH   4   output FIFO depth in words, power of 2, >= 2
//  MISS_MAX 3   consecutive missing frame syncs tolerated before returning to HUNT
// PORTS
//  CLK       in   1     single system clock, rising edge
//  RESET_N   in   1     synchronous reset, active low
//  BIT_EN    in   1     one-cycle strobe: DIN and FS are valid this cycle
//  DIN       in   1     serial PCM data
//  FS        in   1     frame sync, sampled on BIT_EN; high marks ch0 bit7 (MSB)
//  S         out  8     PCM code word, to IN_PCM S
//  CHAN      out  CH_W  channel number of S
//  S_VALID   out  1     S/CHAN hold a valid word
//  S_READY   in   1     consumer accepts the word when S_VALID && S_READY
//  LOCKED    out  1     high in RUN state
//  FRAME_ERR out  1     one-cycle pulse: misplaced FS, or MISS_MAX consecutive FS misses
//  OVF       out  1     one-cycle pulse: completed word dropped because FIFO full
// BEHAVIOUR
//  Reset: S=0, CHAN=0, S_VALID=0, LOCKED=0, FRAME_ERR=0, OVF=0. State HUNT, FIFO empty, counters 0.
//  All sampling happens only on cycles with BIT_EN=1. Other cycles hold the counters.
//  HUNT: ignore DIN until FS=1 on a strobe. That strobe is ch0 bit7. Shift it in, chan=0, bitcnt=7->6.
//   Then go to RUN.
//  RUN: shift DIN into shreg MSB first. Decrement bitcnt each strobe. On the bit0 strobe the byte is complete:
//   push {chan, byte}, then chan = (chan==NCH-1) ? 0 : chan+1.
//  Frame boundary = strobe expected to carry ch0 bit7.
//   FS=1 there: good, miss counter cleared.
//   FS=0 there: flywheel (keep counting) and increment the miss counter.
//   At MISS_MAX misses: FRAME_ERR pulse, go to HUNT.
//  FS=1 on any non-boundary strobe: FRAME_ERR pulse, discard the partial byte (no push), and
//   re-align. That strobe becomes ch0 bit7 and the state stays RUN.
//  FIFO push happens the cycle after the bit0 strobe. Word is visible on S/CHAN with S_VALID=1
//   at the next cycle when the FIFO was empty, so latency from bit0 strobe to S_VALID is 2 CLK.
//  Handshake: S/CHAN stable while S_VALID && !S_READY. Pop on S_VALID && S_READY. No combinational
//   path from S_READY to S_VALID.
//  Full: push while full and no pop -> word dropped, OVF pulse, stored words untouched.
//   Push and pop in the same cycle when full -> both succeed, no OVF.
//  Empty: S_VALID=0. S/CHAN hold their last value.
//  RESET_N low mid-frame: partial byte and FIFO contents lost, outputs return to reset values next edge.
//  Widths: bitcnt 3b, chan CH_W b, miss counter clog2(MISS_MAX+1) b, FIFO entry CH_W+8 b.
// STRUCTURE
//  Shared constants (NCH, CH_W, PCM word width 8, FIFO entry width) go in the encoder-wide include
//   mcac_defs.vh, which the IN_PCM path also reads.
//  State encoding HUNT/RUN is local localparams.
//  One sub-module: pcm_word_fifo. Synchronous FIFO, parameter FDEPTH and width, ports push/pop/full/empty.
//   Registered output head, so the data is stable while not popped.
// TESTING
//  1 Reset, then one clean frame (NCH=32), ch k byte = k^8'hA5, S_READY=1 -> 32 words in order,
//    CHAN 0..31, S = k^A5, no flags.
//  2 DIN bits before the first FS -> nothing output, LOCKED=0. After FS: LOCKED=1, first word CHAN=0.
//  3 FS raised at ch5 bit3 -> FRAME_ERR one cycle, no ch5 word. Next word CHAN=0 with correct value.
//  4 Drop FS for 2 frames -> flywheel, words continue, no error.
//    Drop FS for 3 frames -> FRAME_ERR, LOCKED=0.
//  5 S_READY=0 for 6 word times -> first 4 words kept, 2 OVF pulses.
//    Release -> words CHAN 0..3 out in order, stable while stalled.
//  6 RESET_N low at ch10 bit4, BIT_EN every 2nd cycle -> outputs zero next edge.
//    Relock on the next FS with no stale words.

Source files
------------

// File: rtl/pcm_serial_rx_pkg.sv
// Shared constants and types for the TDM PCM receive front end.
// Word = {channel, 8-bit PCM code}; FIFO entries carry this struct unchanged.
package pcm_serial_rx_pkg;
  localparam int NCH      = 32;
  localparam int CH_W     = $clog2(NCH);
  localparam int PCM_W    = 8;
  localparam int FDEPTH   = 4;
  localparam int MISS_MAX = 3;
  localparam int MISS_W   = $clog2(MISS_MAX + 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic [CH_W-1:0]  chan;
    logic [PCM_W-1:0] pcm;
  } pcm_word_t;

  localparam int ENT_W = $bits(pcm_word_t);
endpackage

// File: rtl/pcm_word_fifo.sv
// Synchronous FIFO with a registered head: dout updates one edge after push-into-empty or pop.
// Push when full is ignored unless a pop happens in the same cycle; dout holds while not popped.
module pcm_word_fifo #(
  parameter int FDEPTH = 4,
  parameter int W      = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(FDEPTH);

  logic [W-1:0]  mem [FDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(FDEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // dout mirrors mem[rd_ptr]; when full with push+pop the write lands in the slot being freed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (do_push && (empty || (do_pop && cnt == (AW+1)'(1)))) dout <= din;
      else if (do_pop && cnt > (AW+1)'(1))                      dout <= mem[rd_nxt];
    end
  end
endmodule

// File: rtl/pcm_serial_rx.sv
// Recovers 8-bit PCM words from a TDM line (FS + bit strobe), tags channel, buffers in a FIFO.
// Bit0 strobe to S_VALID is 2 clocks; full FIFO drops new words and pulses OVF.
module pcm_serial_rx
  import pcm_serial_rx_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             BIT_EN,
  input  logic             DIN,
  input  logic             FS,
  output logic [PCM_W-1:0] S,
  output logic [CH_W-1:0]  CHAN,
  output logic             S_VALID,
  input  logic             S_READY,
  output logic             LOCKED,
  output logic             FRAME_ERR,
  output logic             OVF
);
  rx_state_t         state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [PCM_W-2:0]  shreg_q, shreg_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              push_q, push_d;
  pcm_word_t         word_q, word_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q;
  logic              boundary;
  pcm_word_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign boundary = (bitcnt_q == 3'd7) && (chan_q == '0);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    chan_d   = chan_q;
    shreg_d  = shreg_q;
    miss_d   = miss_q;
    push_d   = 1'b0;
    word_d   = word_q;
    ferr_d   = 1'b0;
    if (BIT_EN) begin
      if (state_q == HUNT) begin
        if (FS) begin
          shreg_d  = {{(PCM_W-2){1'b0}}, DIN};
          chan_d   = '0;
          bitcnt_d = 3'd6;
          miss_d   = '0;
          state_d  = RUN;
        end
      end else if (FS && !boundary) begin
        // Misplaced sync: drop the partial byte and treat this strobe as ch0 bit7.
        ferr_d   = 1'b1;
        shreg_d  = {{(PCM_W-2){1'b0}}, DIN};
        chan_d   = '0;
        bitcnt_d = 3'd6;
        miss_d   = '0;
      end else if (boundary && !FS && miss_q == MISS_W'(MISS_MAX - 1)) begin
        ferr_d   = 1'b1;
        state_d  = HUNT;
        chan_d   = '0;
        bitcnt_d = 3'd0;
        miss_d   = '0;
      end else begin
        if (boundary) miss_d = FS ? '0 : miss_q + 1'b1;
        shreg_d = {shreg_q[PCM_W-3:0], DIN};
        if (bitcnt_q == 3'd0) begin
          push_d      = 1'b1;
          word_d.chan = chan_q;
          word_d.pcm  = {shreg_q, DIN};
          chan_d      = (chan_q == CH_W'(NCH - 1)) ? '0 : chan_q + 1'b1;
          bitcnt_d    = 3'd7;
        end else begin
          bitcnt_d = bitcnt_q - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= HUNT;
      bitcnt_q <= '0;
      chan_q   <= '0;
      shreg_q  <= '0;
      miss_q   <= '0;
      push_q   <= 1'b0;
      word_q   <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      chan_q   <= chan_d;
      shreg_q  <= shreg_d;
      miss_q   <= miss_d;
      push_q   <= push_d;
      word_q   <= word_d;
      ferr_q   <= ferr_d;
      ovf_q    <= push_q && fifo_full && !pop;
    end
  end

  pcm_word_fifo #(
    .FDEPTH (FDEPTH),
    .W      (ENT_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (push_q),
    .din   (word_q),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign S_VALID   = !fifo_empty;
  assign pop       = S_VALID && S_READY;
  assign S         = head.pcm;
  assign CHAN      = head.chan;
  assign LOCKED    = (state_q == RUN);
  assign FRAME_ERR = ferr_q;
  assign OVF       = ovf_q;
endmodule

// File: tb/tb_pcm_serial_rx.sv
// Scoreboard bench for pcm_serial_rx: directed TDM frames, expected words queued at issue time.
module tb_pcm_serial_rx;
  import pcm_serial_rx_pkg::*;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             BIT_EN;
  logic             DIN;
  logic             FS;
  logic             S_READY;
  logic [PCM_W-1:0] S;
  logic [CH_W-1:0]  CHAN;
  logic             S_VALID;
  logic             LOCKED;
  logic             FRAME_ERR;
  logic             OVF;

  pcm_serial_rx dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .BIT_EN    (BIT_EN),
    .DIN       (DIN),
    .FS        (FS),
    .S         (S),
    .CHAN      (CHAN),
    .S_VALID   (S_VALID),
    .S_READY   (S_READY),
    .LOCKED    (LOCKED),
    .FRAME_ERR (FRAME_ERR),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  int        total = 0;
  int        bad = 0;
  int        ferr_seen = 0;
  int        ovf_seen = 0;
  int        exp_ferr = 0;
  int        exp_ovf = 0;
  int        gap = 0;
  pcm_word_t exp_q[$];
  pcm_word_t exp_w;
  pcm_word_t held;
  bit        stall = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      stall = 1'b0;
    end else begin
      if (FRAME_ERR) ferr_seen++;
      if (OVF) ovf_seen++;
      if (S_VALID && S_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got chan=%0d s=%02h, none expected", CHAN, S);
        end else begin
          exp_w = exp_q.pop_front();
          chk("word_chan", int'(CHAN), int'(exp_w.chan));
          chk("word_s", int'(S), int'(exp_w.pcm));
        end
      end
      if (S_VALID && !S_READY) begin
        if (stall) begin
          chk("stall_chan", int'(CHAN), int'(held.chan));
          chk("stall_s", int'(S), int'(held.pcm));
        end
        held.chan = CHAN;
        held.pcm  = S;
        stall     = 1'b1;
      end else begin
        stall = 1'b0;
      end
    end
  end

  // Called at posedge+1; the strobe is sampled on the next rising edge.
  task automatic strobe(input logic d, input logic f);
    BIT_EN = 1'b1;
    DIN    = d;
    FS     = f;
    @(posedge CLK); #1;
    BIT_EN = 1'b0;
    FS     = 1'b0;
    DIN    = 1'b0;
    repeat (gap) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int hi, input int lo, input logic fs_first);
    for (int i = hi; i >= lo; i--) strobe(b[i], fs_first && (i == hi));
  endtask

  task automatic send_frame(input logic [7:0] seed, input logic fs, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      pcm_word_t w;
      w.chan = CH_W'(k);
      w.pcm  = 8'(k) ^ seed;
      exp_q.push_back(w);
      send_bits(w.pcm, 7, 0, fs && (k == 0));
    end
  endtask

  task automatic garbage(input int n);
    for (int i = 0; i < n; i++) strobe(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s"}, int'(S), 0);
    chk({tag, "_chan"}, int'(CHAN), 0);
    chk({tag, "_valid"}, int'(S_VALID), 0);
    chk({tag, "_locked"}, int'(LOCKED), 0);
    chk({tag, "_ferr"}, int'(FRAME_ERR), 0);
    chk({tag, "_ovf"}, int'(OVF), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pcm_word_t w;
    RESET_N = 1'b0;
    BIT_EN  = 1'b0;
    DIN     = 1'b0;
    FS      = 1'b0;
    S_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_zero("reset");
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // Line noise before the first sync must be ignored.
    garbage(20);
    @(negedge CLK);
    chk("prefs_locked", int'(LOCKED), 0);
    chk("prefs_valid", int'(S_VALID), 0);
    @(posedge CLK); #1;

    // Clean frame, ch k = k ^ A5; first word checks the 2-clock latency.
    w.chan = '0;
    w.pcm  = 8'hA5;
    exp_q.push_back(w);
    send_bits(8'hA5, 7, 0, 1'b1);
    @(negedge CLK);
    chk("lat1_valid", int'(S_VALID), 0);
    chk("lock_after_fs", int'(LOCKED), 1);
    @(negedge CLK);
    chk("lat2_valid", int'(S_VALID), 1);
    chk("lat2_s", int'(S), 8'hA5);
    chk("lat2_chan", int'(CHAN), 0);
    @(posedge CLK); #1;
    send_frame(8'hA5, 1'b0, 1, 31);
    chk("clean_ferr", ferr_seen, 0);
    chk("clean_ovf", ovf_seen, 0);

    // Misplaced FS at ch5 bit3: ch5 lost, that strobe starts a new ch0 (byte 3C).
    send_frame(8'h6B, 1'b1, 0, 4);
    send_bits(8'(5) ^ 8'h6B, 7, 4, 1'b0);
    w.chan = '0;
    w.pcm  = 8'h3C;
    exp_q.push_back(w);
    send_bits(8'h3C, 7, 7, 1'b1);
    @(negedge CLK);
    chk("misfs_ferr_hi", int'(FRAME_ERR), 1);
    @(negedge CLK);
    chk("misfs_ferr_lo", int'(FRAME_ERR), 0);
    chk("misfs_locked", int'(LOCKED), 1);
    exp_ferr++;
    @(posedge CLK); #1;
    send_bits(8'h3C, 6, 0, 1'b0);
    send_frame(8'h6B, 1'b0, 1, 31);

    // Two missing syncs ride the flywheel; three drop lock.
    send_frame(8'h5A, 1'b0, 0, 31);
    send_frame(8'h33, 1'b0, 0, 31);
    chk("fly_locked", int'(LOCKED), 1);
    send_frame(8'h0F, 1'b1, 0, 31);
    send_frame(8'h11, 1'b0, 0, 31);
    send_frame(8'h22, 1'b0, 0, 31);
    chk("fly_no_err", ferr_seen, exp_ferr);
    strobe(1'b1, 1'b0);
    @(negedge CLK);
    chk("miss3_ferr", int'(FRAME_ERR), 1);
    @(negedge CLK);
    chk("miss3_unlock", int'(LOCKED), 0);
    exp_ferr++;
    @(posedge CLK); #1;
    garbage(12);

    // Consumer stalls for 6 words: 4 kept, 2 dropped with OVF.
    S_READY = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w.chan = CH_W'(k);
      w.pcm  = 8'(k) ^ 8'hC3;
      if (k < 4) exp_q.push_back(w);
      send_bits(w.pcm, 7, 0, k == 0);
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("ovf_count", ovf_seen, 2);
    chk("ovf_hold_valid", int'(S_VALID), 1);
    exp_ovf += 2;
    S_READY = 1'b1;
    send_frame(8'hC3, 1'b0, 6, 31);

    // Reset mid-frame at ch10 bit4 with a strobe every other cycle.
    gap = 1;
    send_frame(8'h77, 1'b1, 0, 9);
    send_bits(8'(10) ^ 8'h77, 7, 5, 1'b0);
    chk("pre_rst_drained", exp_q.size(), 0);
    RESET_N = 1'b0;
    BIT_EN  = 1'b1;
    DIN     = 1'b1;
    @(posedge CLK); #1;
    BIT_EN = 1'b0;
    DIN    = 1'b0;
    @(negedge CLK);
    chk_zero("midrst");
    exp_q.delete();
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    garbage(10);
    send_frame(8'h96, 1'b1, 0, 31);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge CLK);
    chk("drain", exp_q.size(), 0);
    chk("ferr_total", ferr_seen, exp_ferr);
    chk("ovf_total", ovf_seen, exp_ovf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
